// File: rtl/pbpix_rr_arbiter_pkg.sv
// Shared types for the pbpix round-robin arbiter.
package PbArbPkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned IDW = $clog2(N_REQ_DEF);

  typedef logic [IDW-1:0] src_t;

  // Width of a counter able to hold the value 0..burst inclusive.
  function automatic int unsigned cnt_width(input int unsigned burst);
    return $clog2(burst + 1);
  endfunction

endpackage

// File: rtl/pbpix_rr_arbiter_pick.sv
// Rotated priority pick: first set bit of 'eligible' at or above 'ptr',
// wrapping around to index 0.
module pbpix_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW-1:0] cand;

  // Scan N positions starting at ptr; first hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/pbpix_rr_arbiter.sv
// Round-robin arbiter sharing one pbpix output channel among N_REQ producers.
// Bursts of up to BURST beats per grant, single-entry registered output.
module pbpix_rr_arbiter
  import PbArbPkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 16,
  parameter int unsigned BURST = 8,
  parameter int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          in_rdy,
  output logic [N_REQ-1:0]          in_ack,
  input  logic [N_REQ-1:0]          in_zero,
  input  logic [N_REQ-1:0][DW-1:0]  in_data,
  input  logic [N_REQ-1:0]          cfg_mask,
  output logic                      out_rdy,
  input  logic                      out_ack,
  output logic                      out_zero,
  output logic [DW-1:0]             out_data,
  output logic [IDW-1:0]            out_src,
  output logic                      out_last,
  output logic                      busy
);

  localparam int unsigned CW = cnt_width(BURST);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] ptr_q,   ptr_d;
  logic [CW-1:0]  cnt_q,   cnt_d;

  logic           ob_vld_q,  ob_vld_d;
  logic           ob_zero_q, ob_zero_d;
  logic [DW-1:0]  ob_data_q, ob_data_d;
  logic [IDW-1:0] ob_src_q,  ob_src_d;
  logic           ob_last_q, ob_last_d;

  logic [IDW-1:0] pick_idx;
  logic           pick_found;
  logic           accept;
  logic           last_beat;
  logic [IDW-1:0] next_ptr;

  pbpix_rr_pick #(
    .N  (N_REQ),
    .IW (IDW)
  ) u_pick (
    .eligible (in_rdy & ~cfg_mask),
    .ptr      (ptr_q),
    .idx      (pick_idx),
    .found    (pick_found)
  );

  // Arbitration FSM, burst counting and output-buffer next state.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ob_vld_d  = ob_vld_q;
    ob_zero_d = ob_zero_q;
    ob_data_d = ob_data_q;
    ob_src_d  = ob_src_q;
    ob_last_d = ob_last_q;
    in_ack    = '0;
    accept    = 1'b0;
    last_beat = (cnt_q == CW'(BURST - 1));
    next_ptr  = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + IDW'(1);

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        in_ack[grant_q] = !ob_vld_q || out_ack;
        accept          = in_rdy[grant_q] && (!ob_vld_q || out_ack);
        if (!in_rdy[grant_q]) begin
          state_d = IDLE;
          ptr_d   = next_ptr;
        end else if (accept) begin
          cnt_d = cnt_q + CW'(1);
          if (last_beat) begin
            state_d = IDLE;
            ptr_d   = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // An accept in the same cycle as out_ack refills rather than drains.
    if (accept) begin
      ob_vld_d  = 1'b1;
      ob_zero_d = in_zero[grant_q];
      ob_data_d = in_zero[grant_q] ? '0 : in_data[grant_q];
      ob_src_d  = grant_q;
      ob_last_d = last_beat;
    end else if (out_ack) begin
      ob_vld_d  = 1'b0;
    end
  end

  // State, pointer, counter and output buffer registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      ob_vld_q  <= 1'b0;
      ob_zero_q <= 1'b0;
      ob_data_q <= '0;
      ob_src_q  <= '0;
      ob_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      ob_vld_q  <= ob_vld_d;
      ob_zero_q <= ob_zero_d;
      ob_data_q <= ob_data_d;
      ob_src_q  <= ob_src_d;
      ob_last_q <= ob_last_d;
    end
  end

  assign out_rdy  = ob_vld_q;
  assign out_zero = ob_zero_q;
  assign out_data = ob_data_q;
  assign out_src  = ob_src_q;
  assign out_last = ob_last_q;
  assign busy     = (state_q == GRANT) || ob_vld_q;

endmodule

// File: tb/tb_pbpix_rr_arbiter.sv
// Self-checking bench for pbpix_rr_arbiter: behavioural model plus directed
// literal expectations and a randomized soak.
module tb_pbpix_rr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int BURST = 8;
  localparam int IDW   = 2;

  logic                  i_clk = 1'b0;
  logic                  i_rst;
  logic [N-1:0]          in_rdy, in_ack, in_zero, cfg_mask;
  logic [N-1:0][DW-1:0]  in_data;
  logic                  out_rdy, out_ack, out_zero, out_last, busy;
  logic [DW-1:0]         out_data;
  logic [IDW-1:0]        out_src;

  always #5 i_clk = ~i_clk;

  pbpix_rr_arbiter #(
    .N_REQ (N),
    .DW    (DW),
    .BURST (BURST)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .in_rdy   (in_rdy),
    .in_ack   (in_ack),
    .in_zero  (in_zero),
    .in_data  (in_data),
    .cfg_mask (cfg_mask),
    .out_rdy  (out_rdy),
    .out_ack  (out_ack),
    .out_zero (out_zero),
    .out_data (out_data),
    .out_src  (out_src),
    .out_last (out_last),
    .busy     (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit            gr;    // a requester currently owns the channel
    int            g;     // owner index
    int            cnt;   // beats taken in this grant
    int            ptr;   // where the next search starts
    bit            ov;    // output holds a beat
    bit            oz;
    logic [DW-1:0] od;
    int            os;
    bit            ol;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(input mstate_t s, input logic [N-1:0] rdy,
                                         input logic [N-1:0] zero, input logic [N-1:0] mask,
                                         input logic [N-1:0][DW-1:0] data, input logic ack);
    mstate_t n;
    bit      acc;
    int      k;
    n   = s;
    acc = s.gr && rdy[s.g] && (!s.ov || ack);
    if (acc) begin
      n.ov = 1; n.oz = zero[s.g]; n.od = zero[s.g] ? '0 : data[s.g];
      n.os = s.g; n.ol = (s.cnt + 1 == BURST);
    end else if (ack) begin
      n.ov = 0;
    end
    if (!s.gr) begin
      for (int j = 0; j < N; j++) begin
        k = (s.ptr + j) % N;
        if (!n.gr && rdy[k] && !mask[k]) begin n.gr = 1; n.g = k; n.cnt = 0; end
      end
    end else if (!rdy[s.g]) begin
      n.gr = 0; n.ptr = (s.g + 1) % N;
    end else if (acc) begin
      n.cnt = s.cnt + 1;
      if (n.cnt == BURST) begin n.gr = 0; n.ptr = (s.g + 1) % N; end
    end
    return n;
  endfunction

  function automatic logic [N-1:0] exp_ack_f(input mstate_t s, input logic ack);
    logic [N-1:0] a;
    a = '0;
    if (s.gr && (!s.ov || ack)) a[s.g] = 1'b1;
    return a;
  endfunction

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) m <= '{default: 0};
    else       m <= model_next(m, in_rdy, in_zero, cfg_mask, in_data, out_ack);
  end

  // Per-cycle comparison against the model.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      check("in_ack", in_ack, exp_ack_f(m, out_ack));
      check("out_rdy", out_rdy, m.ov);
      check("busy", busy, m.gr || m.ov);
      if (m.ov) begin
        check("out_data", out_data, m.od);
        check("out_zero", out_zero, m.oz);
        check("out_src", out_src, m.os);
        check("out_last", out_last, m.ol);
      end
    end
  end

  // ---------------- output beat log ----------------
  int            cyc = 0;
  int            q_src[$], q_last[$], q_zero[$], q_cyc[$];
  logic [DW-1:0] q_data[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (!i_rst && out_rdy && out_ack) begin
      q_src.push_back(int'(out_src));
      q_last.push_back(int'(out_last));
      q_zero.push_back(int'(out_zero));
      q_data.push_back(out_data);
      q_cyc.push_back(cyc);
    end
  end

  task automatic clear_q();
    q_src.delete(); q_last.delete(); q_zero.delete(); q_data.delete(); q_cyc.delete();
  endtask

  // ---------------- producers / sink ----------------
  int            rem[N];
  int            sent[N];
  int            rdy_pct  = 100;
  int            zero_pct = 0;
  int            ack_mode = 0;
  int            zero_src = -1;
  int            zero_seq = -1;
  logic [DW-1:0] sentq0[$];

  task automatic step();
    logic [N-1:0] a;
    @(negedge i_clk);
    a = in_ack;
    @(posedge i_clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (in_rdy[i] && a[i]) begin
        if (i == 0) sentq0.push_back(in_zero[0] ? '0 : in_data[0]);
        in_rdy[i] = 1'b0;
        sent[i]++;
        if (rem[i] > 0) rem[i]--;
      end
      if (!in_rdy[i] && rem[i] > 0 && $urandom_range(99) < rdy_pct) begin
        in_rdy[i] = 1'b1;
        if (i == zero_src && sent[i] == zero_seq) begin
          in_zero[i] = 1'b1; in_data[i] = 16'hABCD;
        end else begin
          in_zero[i] = ($urandom_range(99) < zero_pct);
          in_data[i] = DW'($urandom);
        end
      end
    end
    case (ack_mode)
      0:       out_ack = 1'b1;
      1:       out_ack = ($urandom_range(3) != 0);
      default: out_ack = 1'b0;
    endcase
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    #2 i_rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_rdy[i] = 1'b0; in_zero[i] = 1'b0; in_data[i] = '0; rem[i] = 0; sent[i] = 0;
    end
    #1;
    check("rst_out_rdy", out_rdy, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_src", out_src, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ack", in_ack, 0);
    check("rst_busy", busy, 0);
    @(posedge i_clk);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int            k;
    bit            hit;
    int            bad;
    logic [DW-1:0] sd;

    i_rst    = 1'b1;
    in_rdy   = '0;
    in_zero  = '0;
    in_data  = '0;
    cfg_mask = '0;
    out_ack  = 1'b1;
    for (int i = 0; i < N; i++) begin rem[i] = 0; sent[i] = 0; end
    do_reset();

    // A: everyone streaming, sink always ready.
    clear_q();
    for (int i = 0; i < N; i++) rem[i] = 1000;
    steps(45);
    check("a_nbeats", q_src.size() >= 33, 1);
    if (q_src.size() >= 33) begin
      check("a_src0", q_src[0], 0);
      check("a_last6", q_last[6], 0);
      check("a_last7", q_last[7], 1);
      check("a_src8", q_src[8], 1);
      check("a_src16", q_src[16], 2);
      check("a_src24", q_src[24], 3);
      check("a_last31", q_last[31], 1);
      check("a_src32", q_src[32], 0);
      check("a_gap_in_burst", q_cyc[7] - q_cyc[6], 1);
      check("a_gap_grant", q_cyc[8] - q_cyc[7], 2);
    end
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (out_rdy) hit = 1; else step();
    end
    check("a_pre_rst_rdy", out_rdy, 1);
    do_reset();

    // B: requester 2 offers 3 beats then drops, requester 3 waiting.
    clear_q();
    rem[2] = 3; rem[3] = 3;
    steps(20);
    check("b_nbeats", q_src.size(), 6);
    if (q_src.size() == 6) begin
      check("b_src0", q_src[0], 2);
      check("b_src2", q_src[2], 2);
      check("b_last2", q_last[2], 0);
      check("b_src3", q_src[3], 3);
      check("b_src5", q_src[5], 3);
    end

    // C: five-cycle sink stall in the middle of a burst.
    clear_q();
    sentq0.delete();
    rem[0] = 10;
    steps(4);
    ack_mode = 2;
    step();
    sd = out_data;
    steps(4);
    check("c_stall_rdy", out_rdy, 1);
    check("c_stall_data", out_data, sd);
    check("c_stall_ack", in_ack, 0);
    ack_mode = 0;
    steps(20);
    check("c_nbeats", q_src.size(), 10);
    if (q_src.size() == 10 && sentq0.size() == 10) begin
      check("c_data0", q_data[0], sentq0[0]);
      check("c_data9", q_data[9], sentq0[9]);
      check("c_last7", q_last[7], 1);
      check("c_last9", q_last[9], 0);
    end

    // D: third beat of requester 1 is a zero beat carrying junk data.
    clear_q();
    zero_src = 1; zero_seq = sent[1] + 2;
    rem[1] = 8;
    steps(20);
    zero_src = -1;
    check("d_nbeats", q_src.size(), 8);
    if (q_src.size() == 8) begin
      check("d_zero2", q_zero[2], 1);
      check("d_data2", q_data[2], 0);
      check("d_last6", q_last[6], 0);
      check("d_last7", q_last[7], 1);
    end

    // E: mask 0101, then mask requester 1 in the middle of its burst.
    clear_q();
    cfg_mask = 4'b0101;
    for (int i = 0; i < N; i++) rem[i] = 1000;
    steps(30);
    bad = 0;
    foreach (q_src[i]) if (q_src[i] == 0 || q_src[i] == 2) bad++;
    check("e_masked_grants", bad, 0);
    if (q_src.size() >= 17) begin
      check("e_src0", q_src[0], 3);
      check("e_src8", q_src[8], 1);
      check("e_src16", q_src[16], 3);
    end
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (out_rdy && out_src == 1 && !out_last) hit = 1; else step();
    end
    check("e_wait_src1", hit, 1);
    k = q_src.size();
    cfg_mask = 4'b0111;
    steps(40);
    hit = 0;
    for (int i = k; i < q_src.size() && !hit; i++) begin
      if (q_src[i] == 1 && q_last[i] == 1) begin hit = 1; k = i; end
    end
    check("e_burst_finished", hit, 1);
    if (hit && q_src.size() > k + 9) begin
      check("e_after1", q_src[k + 1], 3);
      check("e_after9", q_src[k + 9], 3);
    end
    do_reset();

    // F: randomized traffic, stalls, zeros and mask changes.
    cfg_mask = '0;
    ack_mode = 1;
    rdy_pct  = 60;
    zero_pct = 25;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++)
        if (rem[i] == 0 && !in_rdy[i] && $urandom_range(7) == 0) rem[i] = $urandom_range(20, 1);
      if (t % 64 == 63) cfg_mask = N'($urandom);
      step();
    end
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
